// File: rtl/core_arb_pkg.sv
// Shared types and helpers for the core request arbiter.
package core_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      RESP = 2'd2
   } state_e;

   // Increment an index with wrap-around at n (n need not be a power of two).
   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/core_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping from N-1 back to 0.
module rr_pick #(
   parameter int unsigned N         = 2,
   parameter int unsigned IDX_WIDTH = 1
) (
   input  logic [N-1:0]         req_i,
   input  logic [IDX_WIDTH-1:0] ptr_i,
   output logic [IDX_WIDTH-1:0] sel_o,
   output logic                 any_o
);

   // Scan upward from ptr_i; the first hit wins.
   always_comb begin
      int unsigned idx;
      logic        found;
      sel_o = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         idx = 32'(ptr_i) + i;
         if (idx >= N) idx = idx - N;
         if (!found && req_i[idx]) begin
            sel_o = IDX_WIDTH'(idx);
            found = 1'b1;
         end
      end
      any_o = |req_i;
   end

endmodule

// File: rtl/core_req_arbiter.sv
// Round-robin arbiter sharing one req/gnt/rvalid data port between N_PORTS
// requesters, one outstanding transaction at a time.
module core_req_arbiter
   import core_arb_pkg::*;
#(
   parameter int unsigned N_PORTS    = 2,
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [N_PORTS-1:0]            s_req_i,
   output logic [N_PORTS-1:0]            s_gnt_o,
   output logic [N_PORTS-1:0]            s_rvalid_o,
   input  logic [N_PORTS*ADDR_WIDTH-1:0] s_addr_i,
   input  logic [N_PORTS-1:0]            s_we_i,
   input  logic [N_PORTS*4-1:0]          s_be_i,
   input  logic [N_PORTS*32-1:0]         s_wdata_i,
   output logic [31:0]                   s_rdata_o,
   output logic                          m_req_o,
   input  logic                          m_gnt_i,
   input  logic                          m_rvalid_i,
   output logic [ADDR_WIDTH-1:0]         m_addr_o,
   output logic                          m_we_o,
   output logic [3:0]                    m_be_o,
   output logic [31:0]                   m_wdata_o,
   input  logic [31:0]                   m_rdata_i
);

   localparam int unsigned IDX_WIDTH = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

   state_e               state_q, state_d;
   logic [IDX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
   logic [IDX_WIDTH-1:0] owner_q, owner_d;
   logic [IDX_WIDTH-1:0] sel;
   logic                 any_req;
   logic [IDX_WIDTH-1:0] mux_idx;

   rr_pick #(
      .N         (N_PORTS),
      .IDX_WIDTH (IDX_WIDTH)
   ) u_pick (
      .req_i (s_req_i),
      .ptr_i (rr_ptr_q),
      .sel_o (sel),
      .any_o (any_req)
   );

   // Next-state, grant/response steering and handshake outputs.
   // Outputs are gated by rst_i so they read zero for the whole reset pulse.
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      owner_d    = owner_q;
      mux_idx    = owner_q;
      m_req_o    = 1'b0;
      s_gnt_o    = '0;
      s_rvalid_o = '0;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               mux_idx = sel;
               m_req_o = 1'b1;
               owner_d = sel;
               if (m_gnt_i) begin
                  s_gnt_o[sel] = 1'b1;
                  rr_ptr_d     = IDX_WIDTH'(wrap_inc(32'(sel), N_PORTS));
                  state_d      = RESP;
               end else begin
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            m_req_o = s_req_i[owner_q];
            if (m_gnt_i) begin
               s_gnt_o[owner_q] = 1'b1;
               rr_ptr_d         = IDX_WIDTH'(wrap_inc(32'(owner_q), N_PORTS));
               state_d          = RESP;
            end
         end
         RESP: begin
            if (m_rvalid_i) begin
               s_rvalid_o[owner_q] = 1'b1;
               state_d             = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (rst_i) begin
         mux_idx    = '0;
         m_req_o    = 1'b0;
         s_gnt_o    = '0;
         s_rvalid_o = '0;
      end
   end

   // Attribute mux towards the bridge and shared read data.
   always_comb begin
      m_addr_o  = s_addr_i[int'(mux_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      m_we_o    = s_we_i[mux_idx];
      m_be_o    = s_be_i[int'(mux_idx)*4 +: 4];
      m_wdata_o = s_wdata_i[int'(mux_idx)*32 +: 32];
      s_rdata_o = m_rdata_i;
   end

   // State, round-robin pointer and owner registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         owner_q  <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
      end
   end

`ifndef SYNTHESIS
   a_rvalid_in_resp: assert property (@(posedge clk_i) disable iff (rst_i)
      m_rvalid_i |-> state_q == RESP)
      else $warning("m_rvalid_i outside RESP ignored");

   a_hold_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
      state_q == HOLD |-> s_req_i[owner_q])
      else $error("owner dropped s_req_i while waiting for grant");
`endif

endmodule

// File: tb/tb_core_req_arbiter.sv
module tb_core_req_arbiter;

   typedef struct {
      logic [2:0]  gnt;
      logic [2:0]  rv;
      logic [31:0] rdata;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   exp_t        exp_q[$];
   exp_t        e;

   // DUT with two ports
   logic        rst = 1'b1;
   logic [1:0]  req = '0, we = '0, gnt, rv;
   logic [63:0] addr = {32'h0000_2000, 32'h0000_1000};
   logic [7:0]  be = '0;
   logic [63:0] wdata = '0;
   logic [31:0] rdata, m_addr, m_wdata, m_rdata = '0;
   logic        m_req, m_gnt = 1'b0, m_rvalid = 1'b0, m_we;
   logic [3:0]  m_be;

   core_req_arbiter #(.N_PORTS(2), .ADDR_WIDTH(32)) dut (
      .clk_i(clk), .rst_i(rst), .s_req_i(req), .s_gnt_o(gnt), .s_rvalid_o(rv),
      .s_addr_i(addr), .s_we_i(we), .s_be_i(be), .s_wdata_i(wdata), .s_rdata_o(rdata),
      .m_req_o(m_req), .m_gnt_i(m_gnt), .m_rvalid_i(m_rvalid), .m_addr_o(m_addr),
      .m_we_o(m_we), .m_be_o(m_be), .m_wdata_o(m_wdata), .m_rdata_i(m_rdata)
   );

   // DUT with three ports (non-power-of-two wrap)
   logic        rst3 = 1'b1;
   logic [2:0]  req3 = '0, we3 = '0, gnt3, rv3;
   logic [95:0] addr3 = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
   logic [11:0] be3 = '0;
   logic [95:0] wdata3 = '0;
   logic [31:0] rdata3, m_addr3, m_wdata3, m_rdata3 = '0;
   logic        m_req3, m_gnt3 = 1'b0, m_rvalid3 = 1'b0, m_we3;
   logic [3:0]  m_be3;

   core_req_arbiter #(.N_PORTS(3), .ADDR_WIDTH(32)) dut3 (
      .clk_i(clk), .rst_i(rst3), .s_req_i(req3), .s_gnt_o(gnt3), .s_rvalid_o(rv3),
      .s_addr_i(addr3), .s_we_i(we3), .s_be_i(be3), .s_wdata_i(wdata3), .s_rdata_o(rdata3),
      .m_req_o(m_req3), .m_gnt_i(m_gnt3), .m_rvalid_i(m_rvalid3), .m_addr_o(m_addr3),
      .m_we_o(m_we3), .m_be_o(m_be3), .m_wdata_o(m_wdata3), .m_rdata_i(m_rdata3)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] r, input logic g, input logic v, input logic [31:0] d);
      req = r; m_gnt = g; m_rvalid = v; m_rdata = d;
   endtask

   task automatic test_reset();
      drive(2'b11, 1'b1, 1'b1, 32'h5555_5555);
      @(negedge clk);
      n_tests++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL reset_m_req: got %b exp 0", m_req); end
      n_tests++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b exp 00", gnt); end
      n_tests++; if (rv !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid: got %b exp 00", rv); end
      n_tests++; if (m_addr !== 32'h1000) begin n_fail++; $display("FAIL reset_addr: got %h exp 1000", m_addr); end
      tick();
      drive(2'b00, 1'b0, 1'b0, '0);
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single_read();
      drive(2'b01, 1'b1, 1'b0, '0);
      exp_q.push_back('{gnt: 3'b001, rv: 3'b000, rdata: '0});
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++; if (m_req !== 1'b1) begin n_fail++; $display("FAIL single_m_req: got %b exp 1", m_req); end
      n_tests++; if (m_addr !== 32'h1000) begin n_fail++; $display("FAIL single_addr: got %h exp 1000", m_addr); end
      n_tests++; if (gnt !== e.gnt[1:0]) begin n_fail++; $display("FAIL single_gnt: got %b exp %b", gnt, e.gnt[1:0]); end
      tick();
      drive(2'b00, 1'b0, 1'b0, '0);
      @(negedge clk);
      n_tests++; if (rv !== 2'b00 || m_req !== 1'b0) begin n_fail++; $display("FAIL single_wait: got rv=%b req=%b exp rv=00 req=0", rv, m_req); end
      tick();
      drive(2'b00, 1'b0, 1'b1, 32'hDEAD_BEEF);
      exp_q.push_back('{gnt: 3'b000, rv: 3'b001, rdata: 32'hDEAD_BEEF});
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++; if (rv !== e.rv[1:0]) begin n_fail++; $display("FAIL single_rvalid: got %b exp %b", rv, e.rv[1:0]); end
      n_tests++; if (rdata !== e.rdata) begin n_fail++; $display("FAIL single_rdata: got %h exp %h", rdata, e.rdata); end
      tick();
      // rr_ptr is now 1: with both requesting, port 1 must win
      drive(2'b11, 1'b1, 1'b0, '0);
      exp_q.push_back('{gnt: 3'b010, rv: 3'b000, rdata: '0});
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++; if (gnt !== e.gnt[1:0]) begin n_fail++; $display("FAIL single_ptr1_gnt: got %b exp %b", gnt, e.gnt[1:0]); end
      tick();
      drive(2'b00, 1'b0, 1'b1, 32'h1);
      tick();
      drive(2'b00, 1'b0, 1'b0, '0);
   endtask

   task automatic test_contention();
      logic [1:0]  v;
      logic [31:0] a;
      for (int i = 0; i < 4; i++) begin
         v = (i % 2 == 0) ? 2'b01 : 2'b10;
         a = (i % 2 == 0) ? 32'h1000 : 32'h2000;
         drive(2'b11, 1'b1, 1'b0, '0);
         exp_q.push_back('{gnt: {1'b0, v}, rv: 3'b000, rdata: '0});
         @(negedge clk);
         e = exp_q.pop_front();
         n_tests++; if (gnt !== e.gnt[1:0]) begin n_fail++; $display("FAIL cont_gnt[%0d]: got %b exp %b", i, gnt, e.gnt[1:0]); end
         n_tests++; if (m_addr !== a) begin n_fail++; $display("FAIL cont_addr[%0d]: got %h exp %h", i, m_addr, a); end
         tick();
         drive(2'b11, 1'b0, 1'b1, 32'hA000_0000 + 32'(i));
         exp_q.push_back('{gnt: 3'b000, rv: {1'b0, v}, rdata: 32'hA000_0000 + 32'(i)});
         @(negedge clk);
         e = exp_q.pop_front();
         n_tests++; if (rv !== e.rv[1:0] || rdata !== e.rdata) begin n_fail++; $display("FAIL cont_rv[%0d]: got %b/%h exp %b/%h", i, rv, rdata, e.rv[1:0], e.rdata); end
         tick();
      end
      drive(2'b00, 1'b0, 1'b0, '0);
   endtask

   task automatic test_stall();
      for (int c = 0; c < 4; c++) begin
         drive((c == 0) ? 2'b10 : 2'b11, (c == 3), 1'b0, '0);
         exp_q.push_back('{gnt: (c == 3) ? 3'b010 : 3'b000, rv: 3'b000, rdata: '0});
         @(negedge clk);
         e = exp_q.pop_front();
         n_tests++; if (m_req !== 1'b1 || m_addr !== 32'h2000) begin n_fail++; $display("FAIL stall_hold[%0d]: got req=%b addr=%h exp req=1 addr=2000", c, m_req, m_addr); end
         n_tests++; if (gnt !== e.gnt[1:0]) begin n_fail++; $display("FAIL stall_gnt[%0d]: got %b exp %b", c, gnt, e.gnt[1:0]); end
         tick();
      end
      drive(2'b01, 1'b0, 1'b1, 32'hCAFE_0001);
      exp_q.push_back('{gnt: 3'b000, rv: 3'b010, rdata: 32'hCAFE_0001});
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++; if (rv !== e.rv[1:0]) begin n_fail++; $display("FAIL stall_rv: got %b exp %b", rv, e.rv[1:0]); end
      tick();
      drive(2'b01, 1'b1, 1'b0, '0);
      exp_q.push_back('{gnt: 3'b001, rv: 3'b000, rdata: '0});
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++; if (gnt !== e.gnt[1:0] || m_addr !== 32'h1000) begin n_fail++; $display("FAIL stall_next: got %b/%h exp %b/1000", gnt, m_addr, e.gnt[1:0]); end
      tick();
      drive(2'b00, 1'b0, 1'b1, '0);
      tick();
      drive(2'b00, 1'b0, 1'b0, '0);
   endtask

   task automatic test_write();
      we = 2'b10; be = 8'h30; wdata = {32'h1234_5678, 32'hFFFF_FFFF};
      drive(2'b10, 1'b1, 1'b0, '0);
      exp_q.push_back('{gnt: 3'b010, rv: 3'b000, rdata: '0});
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++; if (m_we !== 1'b1) begin n_fail++; $display("FAIL write_we: got %b exp 1", m_we); end
      n_tests++; if (m_be !== 4'h3) begin n_fail++; $display("FAIL write_be: got %h exp 3", m_be); end
      n_tests++; if (m_wdata !== 32'h1234_5678) begin n_fail++; $display("FAIL write_wdata: got %h exp 12345678", m_wdata); end
      n_tests++; if (gnt !== e.gnt[1:0]) begin n_fail++; $display("FAIL write_gnt: got %b exp %b", gnt, e.gnt[1:0]); end
      tick();
      drive(2'b00, 1'b0, 1'b1, '0);
      exp_q.push_back('{gnt: 3'b000, rv: 3'b010, rdata: '0});
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++; if (rv !== e.rv[1:0]) begin n_fail++; $display("FAIL write_rv: got %b exp %b", rv, e.rv[1:0]); end
      tick();
      drive(2'b00, 1'b0, 1'b0, '0);
      we = '0; be = '0; wdata = '0;
   endtask

   task automatic test_wrap();
      logic [2:0] reqs [3];
      logic [2:0] gnts [3];
      reqs = '{3'b010, 3'b011, 3'b011};
      gnts = '{3'b010, 3'b001, 3'b010};
      rst3 = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         req3 = reqs[i]; m_gnt3 = 1'b1; m_rvalid3 = 1'b0;
         exp_q.push_back('{gnt: gnts[i], rv: 3'b000, rdata: '0});
         @(negedge clk);
         e = exp_q.pop_front();
         n_tests++; if (gnt3 !== e.gnt) begin n_fail++; $display("FAIL wrap_gnt[%0d]: got %b exp %b", i, gnt3, e.gnt); end
         tick();
         req3 = '0; m_gnt3 = 1'b0; m_rvalid3 = 1'b1; m_rdata3 = 32'h33 + 32'(i);
         exp_q.push_back('{gnt: 3'b000, rv: gnts[i], rdata: 32'h33 + 32'(i)});
         @(negedge clk);
         e = exp_q.pop_front();
         n_tests++; if (rv3 !== e.rv || rdata3 !== e.rdata) begin n_fail++; $display("FAIL wrap_rv[%0d]: got %b/%h exp %b/%h", i, rv3, rdata3, e.rv, e.rdata); end
         tick();
      end
      m_rvalid3 = 1'b0;
   endtask

   task automatic test_reset_resp();
      drive(2'b10, 1'b1, 1'b0, '0);
      tick();
      drive(2'b00, 1'b0, 1'b0, '0);
      rst = 1'b1;
      @(negedge clk);
      n_tests++; if (rv !== 2'b00 || gnt !== 2'b00 || m_req !== 1'b0) begin n_fail++; $display("FAIL rresp_in_reset: got rv=%b gnt=%b req=%b exp 00/00/0", rv, gnt, m_req); end
      tick();
      rst = 1'b0;
      drive(2'b00, 1'b0, 1'b1, 32'hBAD0_BAD0);
      exp_q.push_back('{gnt: 3'b000, rv: 3'b000, rdata: '0});
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++; if (rv !== e.rv[1:0]) begin n_fail++; $display("FAIL rresp_late_rv: got %b exp %b", rv, e.rv[1:0]); end
      tick();
      drive(2'b11, 1'b1, 1'b0, '0);
      exp_q.push_back('{gnt: 3'b001, rv: 3'b000, rdata: '0});
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++; if (gnt !== e.gnt[1:0]) begin n_fail++; $display("FAIL rresp_ptr0: got %b exp %b", gnt, e.gnt[1:0]); end
      tick();
      drive(2'b00, 1'b0, 1'b1, '0);
      tick();
      drive(2'b00, 1'b0, 1'b0, '0);
   endtask

   initial begin
      #1;
      test_reset();
      test_single_read();
      test_contention();
      test_stall();
      test_write();
      test_wrap();
      test_reset_resp();
      n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d exp 0", exp_q.size()); end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running exp finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/core_req_arbiter.md
Name: core_req_arbiter

Overview:
- Shares one core-style data port (req/gnt/rvalid, single outstanding transaction) between N_PORTS requesters, e.g. instruction fetch, data LSU and debug.
- Sits directly upstream of the core-to-AXI bridge. Its master port feeds the bridge's data_* inputs.
- Round-robin arbitration. The selection is frozen from first request until grant, so the AXI valid signals downstream never drop or change.
- Response data and rvalid are steered back to the requester that owns the transaction.

Parameters:
- N_PORTS, 2, number of requesters (2..8).
- ADDR_WIDTH, 32, address width of all ports.
- IDX_WIDTH, $clog2(N_PORTS) (minimum 1), width of the owner/pointer index; derived, do not override.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- s_req_i  in  N_PORTS  per-requester request.
- s_gnt_o  out  N_PORTS  per-requester grant.
- s_rvalid_o  out  N_PORTS  per-requester response valid.
- s_addr_i  in  N_PORTS*ADDR_WIDTH  packed addresses; port k at bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- s_we_i  in  N_PORTS  write enable.
- s_be_i  in  N_PORTS*4  byte enables.
- s_wdata_i  in  N_PORTS*32  write data.
- s_rdata_o  out  32  read data, shared; qualified by s_rvalid_o.
- m_req_o  out  1  to bridge data_req_i.
- m_gnt_i  in  1  from bridge data_gnt_o.
- m_rvalid_i  in  1  from bridge data_rvalid_o.
- m_addr_o  out  ADDR_WIDTH  address to bridge.
- m_we_o  out  1  write enable to bridge.
- m_be_o  out  4  byte enables to bridge.
- m_wdata_o  out  32  write data to bridge.
- m_rdata_i  in  32  read data from bridge.

Behaviour:
- Reset (rst_i high, async): state=IDLE, rr_ptr=0, owner=0.
  - All outputs 0: m_req_o, s_gnt_o, s_rvalid_o; m_addr/we/be/wdata follow port 0 (don't care).
- Reset mid-transaction aborts tracking. A late m_rvalid_i after reset is ignored, because the state is IDLE.
- Requester protocol: req held with stable attributes until gnt. rvalid arrives at least 1 cycle after gnt.
- Priority pick (combinational): first asserted s_req_i scanning upward from rr_ptr, wrapping N_PORTS-1 -> 0. The result is sel.
- States:
  - IDLE:
    - If any s_req_i is asserted: mux = sel, m_req_o=1.
    - If m_gnt_i: owner<=sel, s_gnt_o[sel]=1, rr_ptr<=(sel+1) mod N_PORTS, go to RESP.
    - Else: owner<=sel, go to HOLD.
    - No request: stay in IDLE, m_req_o=0.
  - HOLD:
    - mux = owner, m_req_o = s_req_i[owner]. Other requesters are ignored.
    - On m_gnt_i: s_gnt_o[owner]=1, rr_ptr<=owner+1 (wrapped), go to RESP.
  - RESP:
    - m_req_o=0.
    - On m_rvalid_i: s_rvalid_o[owner]=1, s_rdata_o=m_rdata_i (combinational, 0 cycles added), go to IDLE.
- Latency: 0 cycles added on req→gnt and on rvalid. One idle cycle between transactions, since RESP→IDLE does not issue a new request.
- m_rvalid_i outside RESP is ignored; a simulation assertion flags it.
- Dropping s_req_i[owner] while in HOLD is a protocol violation, flagged by a simulation assertion. Hardware keeps state HOLD.
- rr_ptr wraps with modulo N_PORTS arithmetic. Non-power-of-2 N_PORTS is supported.
- s_gnt_o and s_rvalid_o are one-hot or zero in every cycle.

Decomposition:
- Package core_arb_pkg:
  - state enum {IDLE, HOLD, RESP} (2-bit).
  - helper function wrap_inc(idx, n).
- Sub-module rr_pick, combinational:
  - inputs: req vector, ptr.
  - outputs: sel index, any_valid.
  - Reusable by other arbiters in the SoC.

Test Plan:
- Single read, port 0: s_req_i=01, addr 0x1000, m_gnt_i same cycle, m_rvalid_i 2 cycles later with rdata 0xDEADBEEF → s_gnt_o=01, then s_rvalid_o=01 and s_rdata_o=0xDEADBEEF; rr_ptr=1.
- Contention: s_req_i=11 held continuously, N_PORTS=2, gnt immediate, rvalid after 1 cycle → grants alternate 01,10,01,10; m_addr_o alternates between the two ports' addresses.
- Stalled grant: port 1 requests; m_gnt_i low 3 cycles; port 0 requests at cycle 1 → m_req_o stays 1 with port 1's address stable all 4 cycles; on gnt s_gnt_o=10; port 0 is granted next transaction.
- Write pass-through: port 1, we=1, be=0x3, wdata 0x12345678 → m_we_o=1, m_be_o=0x3, m_wdata_o=0x12345678; s_rvalid_o=10 on m_rvalid_i.
- Wrap, N_PORTS=3: rr_ptr=2, s_req_i=011 → port 0 selected; next grant is port 1.
- Reset in RESP: assert rst_i, deassert, then pulse m_rvalid_i → s_rvalid_o stays 0; state IDLE, rr_ptr=0.
